// File: rtl/snn_fitness_sequencer.sv
// snn_fitness_sequencer: drives the XOR spiking network with an optional config write and a 4-pattern fitness evaluation (optional WAIT timeout via SNN_SEQ_TIMEOUT_EN)
module snn_fitness_sequencer #(
  parameter int INT_WIDTH      = 4,
  parameter int CMD_WIDTH      = 3,
  parameter int ADDR_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int FLOAT_WIDTH   = 2 * INT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic                   req_eval,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [CMD_WIDTH-1:0]   req_cmd,
  input  logic [FLOAT_WIDTH-1:0] req_arg,
  output logic                   done_valid,
  output logic [2:0]             fitness,
  output logic [3:0]             pattern_pass,
  output logic [31:0]            latency_sum,
  output logic                   timed_out,
  output logic [ADDR_WIDTH-1:0]  net_addr,
  output logic [CMD_WIDTH-1:0]   net_cmd,
  output logic [FLOAT_WIDTH-1:0] net_cmd_arg,
  output logic                   net_in1,
  output logic                   net_in2,
  input  logic                   net_out,
  input  logic                   net_out_valid,
  input  logic [31:0]            net_out_time
);
  localparam logic [CMD_WIDTH-1:0] CMD_CLEAR = CMD_WIDTH'(2 ** CMD_WIDTH - 3);
  typedef enum logic [2:0] {IDLE, WRITE, CLEAR, WAIT, SCORE, DONE} state_t;
  state_t      state;
  logic        r_eval;
  logic [1:0]  idx;
  logic        cap_out;
  logic        cap_to;
  logic [31:0] cap_time;
  logic [1:0]  nidx;
  logic        pass;
  logic [32:0] sum_ext;
  logic [31:0] sum_sat;
`ifdef SNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
`endif
  // next pattern index, score of the captured result, saturating latency accumulate
  always_comb begin
    nidx    = idx + 2'd1;
    pass    = cap_out == (net_in1 ^ net_in2);
    sum_ext = {1'b0, latency_sum} + {1'b0, cap_time};
    sum_sat = sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
  end
  // sequencer FSM; pattern idx maps to inputs as in1=idx[0], in2=idx[0]^idx[1] (00,11,01,10)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      r_eval       <= 1'b0;
      idx          <= 2'd0;
      cap_out      <= 1'b0;
      cap_to       <= 1'b0;
      cap_time     <= 32'd0;
      req_ready    <= 1'b1;
      done_valid   <= 1'b0;
      fitness      <= 3'd0;
      pattern_pass <= 4'd0;
      latency_sum  <= 32'd0;
      timed_out    <= 1'b0;
      net_addr     <= '1;
      net_cmd      <= '0;
      net_cmd_arg  <= '0;
      net_in1      <= 1'b0;
      net_in2      <= 1'b0;
`ifdef SNN_SEQ_TIMEOUT_EN
      timer        <= '0;
`endif
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          r_eval    <= req_eval;
          idx       <= 2'd0;
          req_ready <= 1'b0;
          if (req_eval) begin
            fitness      <= 3'd0;
            pattern_pass <= 4'd0;
            latency_sum  <= 32'd0;
            timed_out    <= 1'b0;
          end
          if (req_write) begin
            net_addr    <= req_addr;
            net_cmd     <= req_cmd;
            net_cmd_arg <= req_arg;
            state       <= WRITE;
          end else if (req_eval) begin
            net_cmd <= CMD_CLEAR;
            net_in1 <= 1'b0;
            net_in2 <= 1'b0;
            state   <= CLEAR;
          end else begin
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        WRITE: begin
          net_addr    <= '1;
          net_cmd_arg <= '0;
          net_cmd     <= r_eval ? CMD_CLEAR : '0;
          net_in1     <= 1'b0;
          net_in2     <= 1'b0;
          done_valid  <= !r_eval;
          state       <= r_eval ? CLEAR : DONE;
        end
        CLEAR: begin
          net_cmd <= '0;
          cap_to  <= 1'b0;
          state   <= WAIT;
`ifdef SNN_SEQ_TIMEOUT_EN
          timer   <= '0;
`endif
        end
        WAIT: begin
          if (net_out_valid) begin
            cap_out  <= net_out;
            cap_time <= net_out_time;
            state    <= SCORE;
          end
`ifdef SNN_SEQ_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            cap_to <= 1'b1;
            state  <= SCORE;
          end else timer <= timer + 1'b1;
`endif
        end
        SCORE: begin
          if (cap_to) timed_out <= 1'b1;
          else begin
            pattern_pass[idx] <= pass;
            fitness           <= fitness + 3'(pass);
            latency_sum       <= sum_sat;
          end
          if (idx == 2'd3) begin
            done_valid <= 1'b1;
            state      <= DONE;
          end else begin
            idx     <= nidx;
            net_cmd <= CMD_CLEAR;
            net_in1 <= nidx[0];
            net_in2 <= nidx[0] ^ nidx[1];
            state   <= CLEAR;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
